cond_unit: RTL and testbench
============================

// Module: cond_unit
// PURPOSE
//  Consumer side of the ALU flag interface: holds the architectural NZCV flag register,
//  evaluates the 4-bit ARM condition field against it and gates PCS/RegW/MemW per instruction.
//  Sits between decoder+ALU and the register file/memory write path of the multicycle datapath.
//  One registered output stage with valid/ready handshake; execute/squash counters for debug.
// PARAMETERS
//  CNT_W       16       width of exec_cnt / squash_cnt (saturating)
//  FLAG_RST    4'b0000  reset value of flag register {N,Z,C,V}
// PORTS
//  clk         in   1      single clock, rising edge
//  reset_n     in   1      asynchronous, active-low reset
//  in_valid    in   1      instruction control bundle valid
//  in_ready    out  1      unit can accept bundle this cycle
//  Cond        in   4      ARM condition field Instr[31:28]
//  ALUFlags    in   4      {N,Z,C,V} from the ALU for this instruction
//  FlagW       in   2      [1]=write N,Z  [0]=write C,V
//  PCS         in   1      instruction writes PC
//  RegW        in   1      instruction writes register file
//  MemW        in   1      instruction writes memory
//  NoWrite     in   1      compare-type op: suppress RegW
//  out_valid   out  1      registered result valid
//  out_ready   in   1      downstream accepts result
//  PCSrc       out  1      gated PCS (registered)
//  RegWrite    out  1      gated RegW & ~NoWrite (registered)
//  MemWrite    out  1      gated MemW (registered)
//  CondEx      out  1      condition passed (registered)
//  Flags       out  4      current flag register {N,Z,C,V}
//  cnt_clr     in   1      synchronous clear of both counters
//  exec_cnt    out  CNT_W  accepted bundles with CondEx=1
//  squash_cnt  out  CNT_W  accepted bundles with CondEx=0
// BEHAVIOUR
//  Reset: Flags=FLAG_RST; out_valid, PCSrc, RegWrite, MemWrite, CondEx=0; counters=0.
//  Handshake: in_ready = ~out_valid | out_ready (combinational); accept = in_valid & in_ready.
//  Condition (vs. current Flags, pre-update): 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C;
//   0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V; 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V;
//   1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 treated as AL (1).
//  On accept edge: if condex&FlagW[1] Flags[3:2]<=ALUFlags[3:2]; if condex&FlagW[0]
//   Flags[1:0]<=ALUFlags[1:0]; output regs load gated values; out_valid<=1.
//  No accept & out_ready: out_valid<=0, output data regs hold. Neither: all hold.
//  Latency: 1 cycle accept->out_valid. Full throughput when out_ready=1.
//  Back-to-back: bundle k+1 sees flags written by bundle k (no bypass needed).
//  Squashed bundle (condex=0): flags untouched, all gated outputs 0, CondEx=0, still valid.
//  Stall (out_valid & ~out_ready): in_ready=0, flags and outputs frozen.
//  Counters: +1 on accept per condex; saturate at all-ones; cnt_clr wins over increment (->0).
//  reset_n low mid-operation: immediate return to reset state, pending output lost.
// STRUCTURE
//  Package cond_pkg: localparams for the 15 condition encodings, flag bit indices
//   (N=3,Z=2,C=1,V=0), FlagW bit indices.
//  Sub-module cond_check (combinational): Cond[3:0], Flags[3:0] -> condex.
//  Top: flag register, output register + handshake, two saturating counters.
// TESTING
//  Reset: reset_n=0 async mid-cycle -> Flags=0000, out_valid=0, counters 0 immediately.
//  CMP then BEQ: {Cond=1110,FlagW=11,ALUFlags=0100,NoWrite=1,RegW=1}, then {Cond=0000,PCS=1}
//   -> out1 RegWrite=0,CondEx=1, Flags=0100; out2 PCSrc=1,CondEx=1.
//  Squash: Flags=0000, {Cond=0000,RegW=1,MemW=1,FlagW=11,ALUFlags=1111} -> CondEx=0,
//   RegWrite=MemWrite=0, Flags stay 0000, squash_cnt=1.
//  Signed conds: Flags N=1,V=0 -> GE fails, LT passes; N=1,V=1,Z=0 -> GT passes, LE fails.
//  Backpressure: out_ready=0 two cycles with in_valid=1 -> in_ready=0, output/Flags frozen;
//   out_ready=1 -> pending drains, next bundle accepted same edge.
//  Counters: CNT_W=2, 5 executing bundles -> exec_cnt=3 (saturated); cnt_clr with accept -> 0.

Source files
------------

// File: rtl/cond_unit_pkg.sv
// Shared constants for the condition unit: ARM condition encodings,
// flag bit positions inside {N,Z,C,V} and FlagW write-enable bit positions.
package cond_pkg;

  // ARM condition field encodings (Instr[31:28]); 4'b1111 behaves as AL
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // Bit positions inside the {N,Z,C,V} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Bit positions inside FlagW
  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_unit_if.sv
// Instruction control bundle in, gated write-enables out, each side with
// its own valid/ready pair. master = upstream/downstream environment,
// slave = the condition unit.
interface cond_unit_if;

  // Input bundle
  logic       in_valid;
  logic       in_ready;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;

  // Registered result
  logic       out_valid;
  logic       out_ready;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       CondEx;

  modport master (
    output in_valid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, out_ready,
    input  in_ready, out_valid, PCSrc, RegWrite, MemWrite, CondEx
  );

  modport slave (
    input  in_valid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, out_ready,
    output in_ready, out_valid, PCSrc, RegWrite, MemWrite, CondEx
  );

endinterface

// File: rtl/cond_unit_check.sv
// Combinational ARM condition evaluator: decides whether an instruction with
// condition field cond executes given the current {N,Z,C,V} flags.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       condex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // Decode the condition field against the flags
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves condex unassigned (no latch).
    condex = 1'b1;
    case (cond)
      COND_EQ: condex = z;
      COND_NE: condex = ~z;
      COND_CS: condex = c;
      COND_CC: condex = ~c;
      COND_MI: condex = n;
      COND_PL: condex = ~n;
      COND_VS: condex = v;
      COND_VC: condex = ~v;
      COND_HI: condex = c & ~z;
      COND_LS: condex = ~c | z;
      COND_GE: condex = (n == v);
      COND_LT: condex = (n != v);
      COND_GT: condex = ~z & (n == v);
      COND_LE: condex = z | (n != v);
      COND_AL: condex = 1'b1;
      default: condex = 1'b1;  // 4'b1111 executes unconditionally
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Condition unit: architectural NZCV flag register, condition gating of
// PCS/RegW/MemW, one registered output stage with valid/ready handshake and
// saturating execute/squash debug counters.
module cond_unit
  import cond_pkg::*;
#(
  parameter int         CNT_W    = 16,
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic             clk,
  input  logic             reset_n,
  cond_unit_if.slave       bus,
  output logic [3:0]       Flags,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] exec_cnt,
  output logic [CNT_W-1:0] squash_cnt
);

  logic condex;
  logic accept;
  logic out_valid_q;
  logic pcsrc_q, regwrite_q, memwrite_q, condex_q;
  logic [3:0] flags_q;

  // Condition is evaluated against the flags before this bundle's update,
  // so a bundle naturally sees the flags written by its predecessor.
  cond_check u_check (
    .cond   (bus.Cond),
    .flags  (flags_q),
    .condex (condex)
  );

  assign bus.in_ready = ~out_valid_q | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;

  // Architectural flag register: NZ and CV halves written independently
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      flags_q <= FLAG_RST;
    end else if (accept && condex) begin
      if (bus.FlagW[FLAGW_NZ]) flags_q[FLAG_N:FLAG_Z] <= bus.ALUFlags[FLAG_N:FLAG_Z];
      if (bus.FlagW[FLAGW_CV]) flags_q[FLAG_C:FLAG_V] <= bus.ALUFlags[FLAG_C:FLAG_V];
    end
  end

  // Output stage: load gated enables on accept, drop valid once drained
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      pcsrc_q     <= 1'b0;
      regwrite_q  <= 1'b0;
      memwrite_q  <= 1'b0;
      condex_q    <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      pcsrc_q     <= bus.PCS & condex;
      regwrite_q  <= bus.RegW & ~bus.NoWrite & condex;
      memwrite_q  <= bus.MemW & condex;
      condex_q    <= condex;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Saturating debug counters; clear takes priority over counting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exec_cnt   <= '0;
      squash_cnt <= '0;
    end else if (cnt_clr) begin
      exec_cnt   <= '0;
      squash_cnt <= '0;
    end else if (accept) begin
      if (condex && !(&exec_cnt))
        exec_cnt <= exec_cnt + CNT_W'(1);
      if (!condex && !(&squash_cnt))
        squash_cnt <= squash_cnt + CNT_W'(1);
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.PCSrc     = pcsrc_q;
  assign bus.RegWrite  = regwrite_q;
  assign bus.MemWrite  = memwrite_q;
  assign bus.CondEx    = condex_q;
  assign Flags         = flags_q;

endmodule

// File: tb/tb_cond_unit.sv
// Directed self-checking bench for cond_unit (counters narrowed to 2 bits
// so saturation is reachable in a handful of bundles).
module tb_cond_unit;

  localparam int CNT_W = 2;

  logic             clk;
  logic             reset_n;
  logic             cnt_clr;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] exec_cnt;
  logic [CNT_W-1:0] squash_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  cond_unit_if bus ();

  cond_unit #(
    .CNT_W    (CNT_W),
    .FLAG_RST (4'b0000)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus.slave),
    .Flags      (Flags),
    .cnt_clr    (cnt_clr),
    .exec_cnt   (exec_cnt),
    .squash_cnt (squash_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] cond, input logic [3:0] alu, input logic [1:0] fw,
                       input logic pcs, input logic regw, input logic memw, input logic nw);
    bus.in_valid = 1'b1;
    bus.Cond     = cond;
    bus.ALUFlags = alu;
    bus.FlagW    = fw;
    bus.PCS      = pcs;
    bus.RegW     = regw;
    bus.MemW     = memw;
    bus.NoWrite  = nw;
  endtask

  task automatic idle;
    drive(4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  initial begin
    reset_n       = 1'b0;
    cnt_clr       = 1'b0;
    bus.out_ready = 1'b1;
    idle();
    step();
    step();
    reset_n = 1'b1;

    // Reset state
    check("rst_flags",  Flags, 4'b0000);
    check("rst_valid",  bus.out_valid, 1'b0);
    check("rst_condex", bus.CondEx, 1'b0);
    check("rst_exec",   exec_cnt, 2'd0);
    check("rst_squash", squash_cnt, 2'd0);
    check("rst_ready",  bus.in_ready, 1'b1);

    // CMP (AL, sets Z) followed back-to-back by BEQ
    drive(4'hE, 4'b0100, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    check("cmp_valid",  bus.out_valid, 1'b1);
    check("cmp_regw",   bus.RegWrite, 1'b0);
    check("cmp_condex", bus.CondEx, 1'b1);
    check("cmp_flags",  Flags, 4'b0100);
    drive(4'h0, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check("beq_valid",  bus.out_valid, 1'b1);
    check("beq_pcsrc",  bus.PCSrc, 1'b1);
    check("beq_condex", bus.CondEx, 1'b1);
    check("beq_exec",   exec_cnt, 2'd2);
    idle();
    step();
    check("drain_valid", bus.out_valid, 1'b0);
    check("drain_flags", Flags, 4'b0100);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("clr_exec", exec_cnt, 2'd0);

    // Squash: EQ with Z=0
    drive(4'hE, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("zero_flags", Flags, 4'b0000);
    drive(4'h0, 4'b1111, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    check("sq_valid",  bus.out_valid, 1'b1);
    check("sq_condex", bus.CondEx, 1'b0);
    check("sq_regw",   bus.RegWrite, 1'b0);
    check("sq_memw",   bus.MemWrite, 1'b0);
    check("sq_flags",  Flags, 4'b0000);
    check("sq_squash", squash_cnt, 2'd1);
    check("sq_exec",   exec_cnt, 2'd1);

    // Signed conditions: N=1,V=0
    drive(4'hE, 4'b1000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("nv10_flags", Flags, 4'b1000);
    drive(4'hA, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check("ge_condex", bus.CondEx, 1'b0);
    check("ge_regw",   bus.RegWrite, 1'b0);
    drive(4'hB, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check("lt_condex", bus.CondEx, 1'b1);
    check("lt_regw",   bus.RegWrite, 1'b1);

    // Signed conditions: N=1,V=1,Z=0
    drive(4'hE, 4'b1001, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("nv11_flags", Flags, 4'b1001);
    drive(4'hC, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check("gt_condex", bus.CondEx, 1'b1);
    drive(4'hD, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check("le_condex", bus.CondEx, 1'b0);
    check("le_regw",   bus.RegWrite, 1'b0);
    check("sig_exec",   exec_cnt, 2'd3);
    check("sig_squash", squash_cnt, 2'd3);

    // Backpressure: result A held while bundle B waits
    drive(4'hE, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check("bpA_memw",  bus.MemWrite, 1'b1);
    check("bpA_pcsrc", bus.PCSrc, 1'b0);
    bus.out_ready = 1'b0;
    drive(4'hE, 4'b0110, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("bp_ready0", bus.in_ready, 1'b0);
    step();
    check("bp1_valid", bus.out_valid, 1'b1);
    check("bp1_memw",  bus.MemWrite, 1'b1);
    check("bp1_pcsrc", bus.PCSrc, 1'b0);
    check("bp1_flags", Flags, 4'b1001);
    step();
    check("bp2_memw",  bus.MemWrite, 1'b1);
    check("bp2_flags", Flags, 4'b1001);
    check("bp2_ready", bus.in_ready, 1'b0);
    bus.out_ready = 1'b1;
    #1;
    check("bp_ready1", bus.in_ready, 1'b1);
    step();
    check("bpB_valid", bus.out_valid, 1'b1);
    check("bpB_pcsrc", bus.PCSrc, 1'b1);
    check("bpB_memw",  bus.MemWrite, 1'b0);
    check("bpB_flags", Flags, 4'b0110);
    idle();
    step();
    check("bp_drain", bus.out_valid, 1'b0);

    // Counter saturation with 2-bit counters
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("clr2_exec",   exec_cnt, 2'd0);
    check("clr2_squash", squash_cnt, 2'd0);
    for (int i = 0; i < 5; i++) begin
      drive(4'hE, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      check($sformatf("sat_exec%0d", i), exec_cnt, (i < 3) ? i + 1 : 3);
    end

    // Clear wins over a simultaneous accept
    cnt_clr = 1'b1;
    drive(4'hE, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    cnt_clr = 1'b0;
    check("clracc_exec",  exec_cnt, 2'd0);
    check("clracc_valid", bus.out_valid, 1'b1);

    // Asynchronous reset mid-cycle with a pending result
    drive(4'hE, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check("pre_rst_exec", exec_cnt, 2'd1);
    idle();
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_flags",  Flags, 4'b0000);
    check("arst_valid",  bus.out_valid, 1'b0);
    check("arst_regw",   bus.RegWrite, 1'b0);
    check("arst_exec",   exec_cnt, 2'd0);
    step();
    reset_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
